// File: rtl/pc_call_stack.sv
// picoMIPS program counter with signed relative branches, a hardware
// return-address stack for call/ret, a stall input and sticky stack error flags.
module pc_call_stack #(
  parameter int                P_SIZE      = 6,
  parameter int                STACK_DEPTH = 4,
  parameter logic [P_SIZE-1:0] RESET_ADDR  = '0,
  localparam int               CW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              stall,
  input  logic              inc,
  input  logic              branchRel,
  input  logic              branchAbs,
  input  logic              call,
  input  logic              ret,
  input  logic              clrErr,
  input  logic [P_SIZE-1:0] branchAddress,
  output logic [P_SIZE-1:0] addressOut,
  output logic [CW-1:0]     stackCount,
  output logic              stackFull,
  output logic              stackEmpty,
  output logic              overflowErr,
  output logic              underflowErr
);

  logic [P_SIZE-1:0] addr_r;
  logic [CW-1:0]     count_r;
  logic              ovf_r;
  logic              unf_r;
  logic [P_SIZE-1:0] stack_r [STACK_DEPTH];

  logic [P_SIZE-1:0] addr_nxt_s;
  logic [CW-1:0]     count_nxt_s;
  logic [P_SIZE-1:0] top_s;
  logic [P_SIZE-1:0] ret_addr_s;
  logic              push_s;
  logic              ovf_set_s;
  logic              unf_set_s;
  logic              full_s;
  logic              empty_s;

  assign full_s     = (count_r == CW'(STACK_DEPTH));
  assign empty_s    = (count_r == {CW{1'b0}});
  assign ret_addr_s = addr_r + P_SIZE'(1);

  // Top-of-stack read: the entry just below the count pointer.
  always_comb begin
    top_s = {P_SIZE{1'b0}};
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (count_r == CW'(i + 1)) begin
        top_s = stack_r[i];
      end else begin
        top_s = top_s;
      end
    end
  end

  // Next-state selection; stall > ret > call > branchAbs > branchRel > inc > hold.
  always_comb begin
    addr_nxt_s  = addr_r;
    count_nxt_s = count_r;
    push_s      = 1'b0;
    ovf_set_s   = 1'b0;
    unf_set_s   = 1'b0;
    if (stall) begin
      addr_nxt_s = addr_r;
    end else if (ret) begin
      if (!empty_s) begin
        addr_nxt_s  = top_s;
        count_nxt_s = count_r - CW'(1);
      end else begin
        unf_set_s = 1'b1;
      end
    end else if (call) begin
      if (!full_s) begin
        push_s      = 1'b1;
        addr_nxt_s  = branchAddress;
        count_nxt_s = count_r + CW'(1);
      end else begin
        ovf_set_s = 1'b1;
      end
    end else if (branchAbs) begin
      addr_nxt_s = branchAddress;
    end else if (branchRel) begin
      addr_nxt_s = addr_r + branchAddress;
    end else if (inc) begin
      addr_nxt_s = ret_addr_s;
    end else begin
      addr_nxt_s = addr_r;
    end
  end

  // Architectural state; an error event in the same cycle beats clrErr.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      addr_r  <= RESET_ADDR;
      count_r <= {CW{1'b0}};
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      addr_r  <= addr_nxt_s;
      count_r <= count_nxt_s;
      ovf_r   <= ovf_set_s | (ovf_r & ~clrErr);
      unf_r   <= unf_set_s | (unf_r & ~clrErr);
    end
  end

  // Return-address storage, written at the slot the count currently points to.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_r[i] <= {P_SIZE{1'b0}};
      end
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (push_s && (count_r == CW'(i))) begin
          stack_r[i] <= ret_addr_s;
        end else begin
          stack_r[i] <= stack_r[i];
        end
      end
    end
  end

  assign addressOut   = addr_r;
  assign stackCount   = count_r;
  assign stackFull    = full_s;
  assign stackEmpty   = empty_s;
  assign overflowErr  = ovf_r;
  assign underflowErr = unf_r;

endmodule

// File: tb/tb_pc_call_stack.sv
// Self-checking bench for pc_call_stack: directed scenarios plus randomized
// control traffic compared against a queue-based reference model.
module tb_pc_call_stack;

  localparam int P_SIZE = 6;
  localparam int DEPTH  = 4;
  localparam int MODV   = 1 << P_SIZE;
  localparam int CW     = $clog2(DEPTH + 1);

  // control word order: {stall, ret, call, branchAbs, branchRel, inc, clrErr}
  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_CLR   = 7'b0000001;
  localparam logic [6:0] C_INC   = 7'b0000010;
  localparam logic [6:0] C_REL   = 7'b0000100;
  localparam logic [6:0] C_ABS   = 7'b0001000;
  localparam logic [6:0] C_CALL  = 7'b0010000;
  localparam logic [6:0] C_RET   = 7'b0100000;
  localparam logic [6:0] C_STALL = 7'b1000000;

  logic              clk = 1'b0;
  logic              nRst;
  logic              stall, inc, branchRel, branchAbs, call, ret, clrErr;
  logic [P_SIZE-1:0] branchAddress;
  logic [P_SIZE-1:0] addressOut;
  logic [CW-1:0]     stackCount;
  logic              stackFull, stackEmpty, overflowErr, underflowErr;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int addr_m;
  int stk_m[$];
  bit ovf_m, unf_m;

  pc_call_stack #(.P_SIZE(P_SIZE), .STACK_DEPTH(DEPTH), .RESET_ADDR(6'd0)) dut (
    .clk(clk), .nRst(nRst), .stall(stall), .inc(inc), .branchRel(branchRel),
    .branchAbs(branchAbs), .call(call), .ret(ret), .clrErr(clrErr),
    .branchAddress(branchAddress), .addressOut(addressOut), .stackCount(stackCount),
    .stackFull(stackFull), .stackEmpty(stackEmpty), .overflowErr(overflowErr),
    .underflowErr(underflowErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    addr_m = 0;
    stk_m.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
  endtask

  // Apply the documented per-cycle rules to the model using the current inputs.
  task automatic model_step();
    bit ovf_set, unf_set;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (stall) begin
    end else if (ret) begin
      if (stk_m.size() > 0) addr_m = stk_m.pop_back();
      else unf_set = 1'b1;
    end else if (call) begin
      if (stk_m.size() < DEPTH) begin
        stk_m.push_back((addr_m + 1) % MODV);
        addr_m = int'(branchAddress);
      end else ovf_set = 1'b1;
    end else if (branchAbs) addr_m = int'(branchAddress);
    else if (branchRel) addr_m = (addr_m + int'(branchAddress)) % MODV;
    else if (inc) addr_m = (addr_m + 1) % MODV;
    ovf_m = ovf_set ? 1'b1 : (clrErr ? 1'b0 : ovf_m);
    unf_m = unf_set ? 1'b1 : (clrErr ? 1'b0 : unf_m);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},  32'(addressOut),   32'(addr_m));
    check({tag, ".count"}, 32'(stackCount),   32'(stk_m.size()));
    check({tag, ".full"},  32'(stackFull),    32'(stk_m.size() == DEPTH));
    check({tag, ".empty"}, 32'(stackEmpty),   32'(stk_m.size() == 0));
    check({tag, ".ovf"},   32'(overflowErr),  32'(ovf_m));
    check({tag, ".unf"},   32'(underflowErr), 32'(unf_m));
  endtask

  // Drive one cycle of controls, clock it, then compare against the model.
  task automatic op(input logic [6:0] ctl, input logic [P_SIZE-1:0] ba, input string tag);
    {stall, ret, call, branchAbs, branchRel, inc, clrErr} = ctl;
    branchAddress = ba;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    {stall, ret, call, branchAbs, branchRel, inc, clrErr} = 7'b0000000;
    branchAddress = 6'd0;
    nRst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    nRst = 1'b1;

    op(C_INC, 6'd0, "inc1");
    op(C_INC, 6'd0, "inc2");
    op(C_INC, 6'd0, "inc3");
    check("inc3_const", 32'(addressOut), 32'd3);
    op(C_CALL, 6'd9, "pre_areset_call");

    // asynchronous reset between clock edges
    #2 nRst = 1'b0;
    #1;
    model_reset();
    check("areset_addr",  32'(addressOut), 32'd0);
    check("areset_count", 32'(stackCount), 32'd0);
    #3 nRst = 1'b1;

    op(C_ABS, 6'd5,       "abs5");
    op(C_REL, 6'b111101,  "rel_m3");
    check("rel_m3_const", 32'(addressOut), 32'd2);
    op(C_ABS, 6'd62,      "abs62");
    op(C_REL, 6'd4,       "rel_wrap");
    check("rel_wrap_const", 32'(addressOut), 32'd2);
    op(C_ABS, 6'd63,      "abs63");
    op(C_INC, 6'd0,       "inc_wrap");
    check("inc_wrap_const", 32'(addressOut), 32'd0);
    op(C_ABS, 6'd40,      "abs40");

    op(C_ABS,  6'd10, "abs10");
    op(C_CALL, 6'd20, "call20");
    op(C_CALL, 6'd30, "call30");
    check("nest_count", 32'(stackCount), 32'd2);
    op(C_RET, 6'd0, "ret1");
    check("ret1_const", 32'(addressOut), 32'd21);
    op(C_RET, 6'd0, "ret2");
    check("ret2_const", 32'(addressOut), 32'd11);
    check("ret2_empty", 32'(stackEmpty), 32'd1);

    for (int i = 1; i <= DEPTH; i++) op(C_CALL, 6'(i), "fill");
    check("fill_full", 32'(stackFull), 32'd1);
    op(C_CALL, 6'd50, "ovf_call");
    check("ovf_addr_const", 32'(addressOut), 32'd4);
    check("ovf_flag_const", 32'(overflowErr), 32'd1);
    op(C_CLR, 6'd0, "ovf_clr");
    check("ovf_clr_const", 32'(overflowErr), 32'd0);
    for (int i = 0; i < DEPTH; i++) op(C_RET, 6'd0, "drain");

    op(C_ABS, 6'd7, "abs7");
    op(C_RET, 6'd0, "unf_ret");
    check("unf_addr_const", 32'(addressOut), 32'd7);
    check("unf_flag_const", 32'(underflowErr), 32'd1);
    op(C_RET | C_CLR, 6'd0, "unf_set_wins");
    check("unf_set_wins_const", 32'(underflowErr), 32'd1);
    op(C_CLR, 6'd0, "unf_clr");

    op(C_CALL, 6'd33, "pre_stall_call");
    op(C_STALL | C_CALL | C_RET | C_INC, 6'd12, "stall");
    check("stall_addr_const", 32'(addressOut), 32'd33);
    check("stall_count_const", 32'(stackCount), 32'd1);
    op(C_CALL | C_RET, 6'd44, "call_ret");
    check("call_ret_addr_const", 32'(addressOut), 32'd8);
    check("call_ret_count_const", 32'(stackCount), 32'd0);
    check("call_ret_ovf_const", 32'(overflowErr), 32'd0);
    op(C_NONE, 6'd17, "hold");

    for (int n = 0; n < 1500; n++) begin
      logic [6:0] ctl;
      for (int b = 0; b < 7; b++) ctl[b] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) != 0) ctl[6] = 1'b0;
      op(ctl, 6'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
Next-generation program counter for the picoMIPS core, with parametrised address width and a hardware return-address stack. It adds signed relative branching, subroutine call/return, and a pipeline stall input. Sticky overflow/underflow error flags are provided. It sits between the decoder/control unit and the program memory address port, and drives the instruction fetch address every cycle.

Parameters:
- P_SIZE, 6, width of program address and branch operand in bits (>=2).
- STACK_DEPTH, 4, number of return-address entries (>=1).
- RESET_ADDR, 0, value loaded into addressOut on reset (P_SIZE bits).

Ports:
- clk  input  1  system clock, rising edge.
- nRst  input  1  asynchronous, active-low reset.
- stall  input  1  freeze all state this cycle.
- inc  input  1  addressOut <= addressOut + 1.
- branchRel  input  1  addressOut <= addressOut + branchAddress; offset is signed two's complement.
- branchAbs  input  1  addressOut <= branchAddress.
- call  input  1  push addressOut+1, then jump to branchAddress.
- ret  input  1  pop top of stack into addressOut.
- clrErr  input  1  clear sticky error flags.
- branchAddress  input  P_SIZE  branch target or signed offset.
- addressOut  output  P_SIZE  current fetch address (registered).
- stackCount  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stackFull  output  1  stackCount == STACK_DEPTH (combinational from count).
- stackEmpty  output  1  stackCount == 0 (combinational from count).
- overflowErr  output  1  sticky; a call was attempted while full.
- underflowErr  output  1  sticky; a ret was attempted while empty.

Behaviour:
- Reset (async, nRst=0):
  - addressOut=RESET_ADDR, stackCount=0, overflowErr=0, underflowErr=0.
  - Stack contents are don't-care.
  - Reset asserted mid-operation discards any pending action immediately.
- All updates happen on the rising clk edge; one-cycle latency from control input to addressOut.
- Action priority per cycle, exactly one applied: stall > ret > call > branchAbs > branchRel > inc > hold.
- stall=1:
  - No change to addressOut, stack, or count.
  - clrErr is still honoured.
- ret, count>0:
  - addressOut <= top entry; count decrements.
- ret, count==0:
  - addressOut holds; underflowErr <= 1.
- call, count<STACK_DEPTH:
  - Push (addressOut+1) mod 2^P_SIZE; count increments.
  - addressOut <= branchAddress.
- call, count==STACK_DEPTH:
  - No push, no jump, addressOut holds; overflowErr <= 1.
- branchRel:
  - Sum is computed in P_SIZE bits and wraps modulo 2^P_SIZE (e.g. P_SIZE=6: 2 + 6'b111110 = 0).
- inc:
  - Wraps 2^P_SIZE-1 -> 0.
- No control input asserted: addressOut holds.
- Stack is LIFO and contents are visible only through ret.
- clrErr=1:
  - Both flags are cleared that edge.
  - If an error event occurs in the same cycle, the set wins (flag = 1).
- Simultaneous call+ret: ret wins and call is ignored entirely (no push, no flag).
- Stack storage is a register array indexed by count; no memory macro.

Test Plan:
- Reset, then inc x3 -> addressOut 0,1,2,3. Assert nRst low mid-sequence -> addressOut=0 and stackCount=0 immediately (asynchronous).
- At addr 5: branchRel=6'b111101 (-3) -> 2. At addr 62: branchRel=+4 -> 2 (wrap). At 63: inc -> 0. branchAbs=40 -> 40.
- Nested calls at 10 (to 20), then at 20 (to 30) -> stackCount=2. ret -> 21, ret -> 11, stackEmpty=1.
- STACK_DEPTH=4: four calls fill the stack (stackFull=1). Fifth call at addr A -> addressOut stays A, overflowErr=1, count=4. clrErr -> flag 0.
- ret with empty stack at addr 7 -> addressOut=7, underflowErr=1. clrErr asserted in the same cycle as a second underflow -> flag remains 1.
- stall=1 with call/ret/inc asserted -> addressOut and count unchanged. Same-cycle call+ret with count=1 -> pop only, count=0, no flag set.
